sqrt_controller: RTL

Control FSM for the floating-point square-root datapath. It sits directly upstream of the 8×32 register file and the FP ALU, and runs Newton's iteration root = (x + n/x)/2 as a fixed micro-program. It drives the register-file write enable and write/read addresses, ALU opcode and start, and the input-mux select. It reports done, error and iteration count.

---
 rtl/sqrt_controller.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/sqrt_controller.sv
// sqrt_controller: sequences the register file and FP ALU through Newton's
// iteration root = (x + n/x)/2. It runs as a fixed eight-step micro-program
// and reports done, error (iteration cap reached) and the iteration count.
module sqrt_controller #(
  parameter int ADDR_WIDTH = 3,
  parameter int MAX_ITER   = 16,
  parameter int ITER_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  alu_done_i,
  input  logic                  lt_i,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] addr_wr_o,
  output logic [ADDR_WIDTH-1:0] addr_rda_o,
  output logic [ADDR_WIDTH-1:0] addr_rdb_o,
  output logic [2:0]            alu_op_o,
  output logic                  alu_start_o,
  output logic                  sel_ext_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ITER_WIDTH-1:0] iter_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READ  = 3'd2,
    EXEC  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3,
    S4 = 3'd4, S5 = 3'd5, S6 = 3'd6, S7 = 3'd7
  } step_t;

  localparam logic [2:0] OP_ADD    = 3'd0;
  localparam logic [2:0] OP_SUB    = 3'd1;
  localparam logic [2:0] OP_DIV    = 3'd3;
  localparam logic [2:0] OP_CMPABS = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] R0 = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] R1 = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] R2 = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] R3 = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] R4 = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] R5 = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] R6 = ADDR_WIDTH'(6);
  localparam logic [ADDR_WIDTH-1:0] R7 = ADDR_WIDTH'(7);

  localparam logic [ITER_WIDTH-1:0] ITER_CAP = ITER_WIDTH'(MAX_ITER);

  state_t                state, state_next;
  step_t                 step, step_next;
  logic                  first_exec, first_exec_next;
  logic [ITER_WIDTH-1:0] iter, iter_next;
  logic                  err, err_next;

  logic [ADDR_WIDTH-1:0] step_dst, step_src_a, step_src_b;
  logic [2:0]            step_op;
  logic [ITER_WIDTH-1:0] iter_inc;

  assign iter_inc = iter + ITER_WIDTH'(1);
  assign iter_o   = iter;
  assign err_o    = err;

  // Micro-program ROM: destination, operands and opcode of the current step.
  always_comb begin
    step_dst   = R0;
    step_src_a = R0;
    step_src_b = R0;
    step_op    = OP_ADD;
    case (step)
      S0: begin step_dst = R2; step_src_a = R1; step_src_b = R0; step_op = OP_ADD;    end
      S1: begin step_dst = R4; step_src_a = R1; step_src_b = R2; step_op = OP_DIV;    end
      S2: begin step_dst = R4; step_src_a = R2; step_src_b = R4; step_op = OP_ADD;    end
      S3: begin step_dst = R3; step_src_a = R4; step_src_b = R5; step_op = OP_DIV;    end
      S4: begin step_dst = R4; step_src_a = R2; step_src_b = R3; step_op = OP_SUB;    end
      S5: begin step_dst = R0; step_src_a = R4; step_src_b = R6; step_op = OP_CMPABS; end
      S6: begin step_dst = R7; step_src_a = R3; step_src_b = R0; step_op = OP_ADD;    end
      S7: begin step_dst = R2; step_src_a = R3; step_src_b = R0; step_op = OP_ADD;    end
      default: ;
    endcase
  end

  // State, step, iteration counter and error flag; reset aborts at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      step       <= S0;
      first_exec <= 1'b0;
      iter       <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_next;
      step       <= step_next;
      first_exec <= first_exec_next;
      iter       <= iter_next;
      err        <= err_next;
    end
  end

  // Next-state sequencing through the micro-program and S5 branch decision.
  always_comb begin
    state_next      = state;
    step_next       = step;
    first_exec_next = 1'b0;
    iter_next       = iter;
    err_next        = err;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_next = LOAD;
          step_next  = S0;
          iter_next  = '0;
          err_next   = 1'b0;
        end
      end
      LOAD: begin
        state_next = READ;
        step_next  = S0;
      end
      READ: begin
        state_next      = EXEC;
        first_exec_next = 1'b1;
      end
      EXEC: begin
        if (alu_done_i) begin
          if (step == S5) begin
            state_next = READ;
            if (lt_i) begin
              step_next = S6;
            end else begin
              if (iter != ITER_CAP) iter_next = iter_inc;
              if (iter_inc == ITER_CAP || iter == ITER_CAP) begin
                err_next  = 1'b1;
                step_next = S6;
              end else begin
                step_next = S7;
              end
            end
          end else begin
            state_next = WRITE;
          end
        end
      end
      WRITE: begin
        if (step == S6) begin
          state_next = DONE;
        end else if (step == S7) begin
          state_next = READ;
          step_next  = S1;
        end else begin
          state_next = READ;
          step_next  = step_t'(step + 3'd1);
        end
      end
      DONE: begin
        state_next = IDLE;
        step_next  = S0;
      end
      default: begin
        state_next = IDLE;
        step_next  = S0;
      end
    endcase
  end

  // Output decode from state and step only, so no input reaches an output.
  always_comb begin
    we_o        = 1'b0;
    addr_wr_o   = '0;
    addr_rda_o  = '0;
    addr_rdb_o  = '0;
    alu_op_o    = 3'd0;
    alu_start_o = 1'b0;
    sel_ext_o   = 1'b0;
    busy_o      = (state != IDLE);
    done_o      = 1'b0;
    case (state)
      LOAD: begin
        we_o      = 1'b1;
        addr_wr_o = R1;
        sel_ext_o = 1'b1;
      end
      READ: begin
        addr_rda_o = step_src_a;
        addr_rdb_o = step_src_b;
        alu_op_o   = step_op;
      end
      EXEC: begin
        addr_rda_o  = step_src_a;
        addr_rdb_o  = step_src_b;
        alu_op_o    = step_op;
        alu_start_o = first_exec;
      end
      WRITE: begin
        we_o      = 1'b1;
        addr_wr_o = step_dst;
      end
      DONE: done_o = 1'b1;
      default: ;
    endcase
  end

endmodule
